// File: rtl/ddr3_int_ex_lfsr_pkg.sv
// Shared definitions for the DDR3 example-driver 8-bit LFSR data pattern
// (x^8+x^4+x^3+x^2+1), used by both the write generator and the read checker.
package ddr3_int_ex_lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } chk_state_t;

  // Bit 0 takes the feedback, every other bit shifts up and picks up the
  // feedback wherever the polynomial has a tap.
  function automatic logic [LFSR_W-1:0] lfsr8_step(input logic [LFSR_W-1:0] e);
    logic [LFSR_W-1:0] n;
    n[0] = e[LFSR_W-1];
    for (int i = 1; i < LFSR_W; i++) begin
      n[i] = e[i-1] ^ (LFSR_TAPS[i] & e[LFSR_W-1]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ddr3_int_ex_lfsr8_chk.sv
// Read-side checker for the DDR3 example driver's LFSR data pattern.
// Define DDR3_INT_EX_LFSR_CHK_SYNC_EN to seed the expected stream from the first beat.
//
// state | meaning
// IDLE  | restarted, waiting one cycle with enable high before comparing
// CHECK | comparing every valid beat against the local LFSR
// DONE  | CHECK_LEN beats compared, further beats ignored
module ddr3_int_ex_lfsr8_chk
  import ddr3_int_ex_lfsr_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'd32,
  parameter int          CHECK_LEN = 256,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [LFSR_W-1:0]    ldata,
  input  logic                 rdata_valid,
  input  logic [LFSR_W-1:0]    rdata,
  output logic [LFSR_W-1:0]    expected,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [LFSR_W-1:0]    first_err_exp,
  output logic [LFSR_W-1:0]    first_err_got,
  output logic [15:0]          beat_cnt
);

  localparam logic [LFSR_W-1:0] SEED_V    = SEED[LFSR_W-1:0];
  localparam logic [15:0]       LAST_BEAT = 16'(CHECK_LEN);

  chk_state_t            state_q;
  logic [LFSR_W-1:0]     exp_q;
  logic [LFSR_W-1:0]     ferr_exp_q;
  logic [LFSR_W-1:0]     ferr_got_q;
  logic                  fail_q;
  logic [ERR_CNT_W-1:0]  err_q;
  logic [15:0]           beat_q;
  logic [15:0]           beat_nxt;
  logic                  sync_beat;
  logic                  mismatch;

`ifdef DDR3_INT_EX_LFSR_CHK_SYNC_EN
  // Armed on every restart, consumed by the first accepted beat in CHECK.
  logic sync_pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pend_q <= 1'b1;
    end else if (!enable || state_q == IDLE) begin
      sync_pend_q <= 1'b1;
    end else if (!load && state_q == CHECK && rdata_valid) begin
      sync_pend_q <= 1'b0;
    end
  end

  assign sync_beat = sync_pend_q;
`else
  assign sync_beat = 1'b0;
`endif

  assign beat_nxt = beat_q + 16'd1;
  assign mismatch = ~sync_beat & (rdata != exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      exp_q      <= SEED_V;
      fail_q     <= 1'b0;
      err_q      <= '0;
      beat_q     <= '0;
      ferr_exp_q <= '0;
      ferr_got_q <= '0;
    end else if (!enable) begin
      state_q    <= IDLE;
      exp_q      <= SEED_V;
      fail_q     <= 1'b0;
      err_q      <= '0;
      beat_q     <= '0;
      ferr_exp_q <= '0;
      ferr_got_q <= '0;
    end else if (load) begin
      // A beat arriving with load is dropped without stepping.
      exp_q <= ldata;
    end else begin
      case (state_q)
        IDLE: state_q <= CHECK;
        CHECK: begin
          if (rdata_valid) begin
            beat_q <= beat_nxt;
            exp_q  <= sync_beat ? lfsr8_step(rdata) : lfsr8_step(exp_q);
            if (beat_nxt == LAST_BEAT) state_q <= DONE;
            if (mismatch) begin
              if (err_q != {ERR_CNT_W{1'b1}}) err_q <= err_q + ERR_CNT_W'(1);
              if (!fail_q) begin
                fail_q     <= 1'b1;
                ferr_exp_q <= exp_q;
                ferr_got_q <= rdata;
              end
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign expected      = exp_q;
  assign busy          = (state_q == CHECK);
  assign done          = (state_q == DONE);
  assign pass          = done & ~fail_q;
  assign fail          = fail_q;
  assign err_cnt       = err_q;
  assign first_err_exp = ferr_exp_q;
  assign first_err_got = ferr_got_q;
  assign beat_cnt      = beat_q;

endmodule

// File: tb/tb_ddr3_int_ex_lfsr8_chk.sv
// Self-checking bench for ddr3_int_ex_lfsr8_chk: directed cases plus randomised
// valid gaps/corruption compared against a beat-level model of the checker.
module tb_ddr3_int_ex_lfsr8_chk;

  localparam int LEN = 256;
`ifdef DDR3_INT_EX_LFSR_CHK_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  ldata = 8'h00;
  logic        rdata_valid = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic [7:0]  expected;
  logic        busy, done, pass, fail;
  logic [15:0] err_cnt;
  logic [7:0]  first_err_exp, first_err_got;
  logic [15:0] beat_cnt;

  ddr3_int_ex_lfsr8_chk #(
    .SEED(32'd32), .CHECK_LEN(LEN), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .ldata(ldata),
    .rdata_valid(rdata_valid), .rdata(rdata), .expected(expected), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .err_cnt(err_cnt),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Polynomial arithmetic: multiply by x, reduce modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] nxt(input logic [7:0] v);
    int x;
    x = int'(v) * 2;
    if (x >= 256) x = (x - 256) ^ 'h1D;
    return 8'(x);
  endfunction

  logic [7:0] seq [0:LEN+63];

  // Beat-level reference model
  int         m_phase;   // 0 waiting, 1 comparing, 2 finished
  logic [7:0] m_exp, m_fe, m_fg;
  int         m_beats, m_errs;
  bit         m_fail, m_sync;

  task automatic model_reset();
    m_phase = 0; m_exp = 8'h20; m_fe = 8'h00; m_fg = 8'h00;
    m_beats = 0; m_errs = 0; m_fail = 0; m_sync = 1;
  endtask

  task automatic model_step();
    if (reset || !enable) begin
      model_reset();
    end else if (load) begin
      m_exp = ldata;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && rdata_valid) begin
      if (SYNC && m_sync) begin
        m_sync = 0;
        m_exp = nxt(rdata);
      end else begin
        if (rdata != m_exp) begin
          if (m_errs < 65535) m_errs++;
          if (!m_fail) begin m_fail = 1; m_fe = m_exp; m_fg = rdata; end
        end
        m_exp = nxt(m_exp);
      end
      m_beats++;
      if (m_beats == LEN) m_phase = 2;
    end
  endtask

  task automatic check_model();
    chk("exp", expected, m_exp);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("pass", pass, (m_phase == 2) && !m_fail);
    chk("fail", fail, m_fail);
    chk("err_cnt", err_cnt, m_errs);
    chk("ferr_exp", first_err_exp, m_fe);
    chk("ferr_got", first_err_got, m_fg);
    chk("beat_cnt", beat_cnt, m_beats);
  endtask

  task automatic tick(input bit en, input bit ld, input logic [7:0] lv,
                      input bit v, input logic [7:0] d);
    enable = en; load = ld; ldata = lv; rdata_valid = v; rdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    bit v;

    seq[0] = 8'h20;
    for (int i = 1; i < LEN + 64; i++) seq[i] = nxt(seq[i-1]);
    model_reset();

    // Reset values
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_exp", expected, 8'h20);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat", beat_cnt, 0);
    check_model();
    reset = 1'b0;

    // Clean gapless run
    tick(1, 0, 0, 0, 0);
    chk("enter_busy", busy, 1);
    for (int i = 0; i < LEN; i++) begin
      tick(1, 0, 0, 1, seq[i]);
      if (i == 0) chk("seq_1", expected, 8'h40);
      if (i == 1) chk("seq_2", expected, 8'h80);
      if (i == 2) chk("seq_3", expected, 8'h1D);
    end
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_cnt, 0);
    chk("clean_beat", beat_cnt, 256);
    tick(1, 0, 0, 1, 8'h00);
    chk("done_ignore_beat", beat_cnt, 256);
    chk("done_ignore_err", err_cnt, 0);

    // Corrupt beats 3 and 10
    tick(0, 0, 0, 0, 0);
    chk("restart_exp", expected, 8'h20);
    chk("restart_done", done, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < LEN; i++) begin
      d = seq[i];
      if (i == 3) d = 8'h1C;
      if (i == 10) d = seq[i] ^ 8'h01;
      tick(1, 0, 0, 1, d);
      if (i == 3) begin
        chk("c3_fail", fail, 1);
        chk("c3_err", err_cnt, 1);
        chk("c3_fexp", first_err_exp, 8'h1D);
        chk("c3_fgot", first_err_got, 8'h1C);
      end
      if (i == 4) chk("c4_continue", expected, seq[5]);
    end
    chk("corr_err", err_cnt, 2);
    chk("corr_pass", pass, 0);
    chk("corr_done", done, 1);
    chk("corr_fexp", first_err_exp, 8'h1D);
    chk("corr_fgot", first_err_got, 8'h1C);

    // Random valid gaps, clean data
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    n = 0;
    while (m_phase != 2 && n < 3000) begin
      v = 1'($urandom_range(0, 1));
      tick(1, 0, 0, v, v ? seq[m_beats] : 8'($urandom));
      n++;
    end
    chk("gap_done", done, 1);
    chk("gap_pass", pass, 1);
    chk("gap_err", err_cnt, 0);
    chk("gap_beat", beat_cnt, 256);

    // Random gaps with random corruption
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    n = 0;
    while (m_phase != 2 && n < 3000) begin
      v = 1'($urandom_range(0, 1));
      d = seq[m_beats];
      if ($urandom_range(0, 15) == 0) d = d ^ 8'($urandom_range(1, 255));
      tick(1, 0, 0, v, d);
      n++;
    end
    chk("rnd_done", done, 1);

    // Load drops the coincident beat
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 8'h80, 1, 8'h55);
    chk("ld_exp", expected, 8'h80);
    chk("ld_beat", beat_cnt, 0);
    chk("ld_err", err_cnt, 0);
    tick(1, 0, 0, 1, 8'h80);
    tick(1, 0, 0, 1, 8'h1D);
    chk("ld_after_err", err_cnt, 0);
    chk("ld_after_beat", beat_cnt, 2);
    chk("ld_after_exp", expected, 8'h3A);

    // enable low after two errors
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, seq[0]);
    tick(1, 0, 0, 1, seq[1] ^ 8'hFF);
    tick(1, 0, 0, 1, seq[2] ^ 8'h0F);
    chk("en_pre_err", err_cnt, 2);
    tick(0, 0, 0, 0, 0);
    chk("en_exp", expected, 8'h20);
    chk("en_err", err_cnt, 0);
    chk("en_fail", fail, 0);
    chk("en_busy", busy, 0);
    chk("en_fexp", first_err_exp, 8'h00);

    // Asynchronous reset mid-check, sampled away from any clock edge
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, seq[0]);
    tick(1, 0, 0, 1, seq[1] ^ 8'h01);
    tick(1, 0, 0, 1, seq[2]);
    chk("ar_pre_fail", fail, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("ar_exp", expected, 8'h20);
    chk("ar_err", err_cnt, 0);
    chk("ar_fail", fail, 0);
    chk("ar_busy", busy, 0);
    chk("ar_beat", beat_cnt, 0);
    chk("ar_fgot", first_err_got, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    check_model();

`ifdef DDR3_INT_EX_LFSR_CHK_SYNC_EN
    // Align to a stream starting mid-sequence at 0x3A
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 8'h3A);
    chk("sync_exp", expected, 8'h74);
    chk("sync_beat", beat_cnt, 1);
    tick(1, 0, 0, 1, 8'h74);
    chk("sync_b2_err", err_cnt, 0);
    for (int i = 6; i < 26; i++) tick(1, 0, 0, 1, seq[i]);
    chk("sync_run_err", err_cnt, 0);
    chk("sync_run_beat", beat_cnt, 22);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
